// File: rtl/button_gesture_decoder_pkg.sv
// Shared types and width helpers for the button gesture decoder and its UI siblings.
package button_gesture_decoder_pkg;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_PRESSED     = 3'd1,
      S_LONG        = 3'd2,
      S_WAIT_SECOND = 3'd3,
      S_SECOND      = 3'd4
   } gesture_state_t;

   // Number of bits needed to hold any value in 0..value.
   function automatic int bits_for(input int value);
      int b;
      b = 1;
      while ((1 << b) <= value) b = b + 1;
      return b;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_gesture_decoder_if.sv
// Button level in, gesture events out; master is the UI side, slave is the decoder.
interface button_gesture_decoder_if;
   logic i_button;
   logic o_short;
   logic o_long;
   logic o_double;
   logic o_held;

   modport master (
      output i_button,
      input  o_short,
      input  o_long,
      input  o_double,
      input  o_held
   );

   modport slave (
      input  i_button,
      output o_short,
      output o_long,
      output o_double,
      output o_held
   );
endinterface

// File: rtl/button_gesture_decoder_tick_generator.sv
// Free-running prescaler: o_tick is high for one cycle every 2^TICK_SCALE cycles.
module tick_generator #(
   parameter int TICK_SCALE = 15
) (
   input  logic i_clock,
   input  logic i_reset_n,
   output logic o_tick
);

   logic [TICK_SCALE-1:0] prescale;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + TICK_SCALE'(1);
      end
   end

   assign o_tick = &prescale;

endmodule

// File: rtl/button_gesture_decoder.sv
// Turns debounced button press/release timing into short, long and double-click pulses.
//
//   state         | meaning
//   S_IDLE        | button released, no gesture in progress
//   S_PRESSED     | first press held, timing toward long threshold
//   S_LONG        | long threshold passed, button still held (o_held)
//   S_WAIT_SECOND | first press released, waiting for a second press
//   S_SECOND      | double click reported, waiting for release
module button_gesture_decoder
   import button_gesture_decoder_pkg::*;
#(
   parameter int TICK_SCALE   = 15,
   parameter int LONG_TICKS   = 24,
   parameter int DOUBLE_TICKS = 8
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   button_gesture_decoder_if.slave  bus
);

   localparam int               CNT_W       = bits_for(max_int(LONG_TICKS, DOUBLE_TICKS));
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);

   logic           sync_meta;
   logic           sync_level;
   logic           level_d;
   logic           rise;
   logic           fall;
   logic           tick;
   logic           long_hit;
   logic           double_hit;
   logic [CNT_W-1:0] interval;
   gesture_state_t state;
   logic           short_q;
   logic           long_q;
   logic           double_q;
   logic           held_q;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_meta  <= 1'b0;
         sync_level <= 1'b0;
         level_d    <= 1'b0;
      end else begin
         sync_meta  <= bus.i_button;
         sync_level <= sync_meta;
         level_d    <= sync_level;
      end
   end

   assign rise = sync_level & ~level_d;
   assign fall = ~sync_level & level_d;

   tick_generator #(
      .TICK_SCALE (TICK_SCALE)
   ) u_tick (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .o_tick    (tick)
   );

   // A threshold is "reached" in the tick cycle that would bring the count to it.
   assign long_hit   = tick && (interval == LONG_LAST);
   assign double_hit = tick && (interval == DOUBLE_LAST);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= S_IDLE;
         interval <= '0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         if (tick && (interval != CNT_MAX)) begin
            interval <= interval + CNT_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (rise) begin
                  state    <= S_PRESSED;
                  interval <= '0;
               end
            end
            S_PRESSED: begin
               // Release wins over a coincident long threshold.
               if (fall) begin
                  state    <= S_WAIT_SECOND;
                  interval <= '0;
               end else if (long_hit) begin
                  state    <= S_LONG;
                  interval <= '0;
                  long_q   <= 1'b1;
                  held_q   <= 1'b1;
               end
            end
            S_LONG: begin
               if (fall) begin
                  state    <= S_IDLE;
                  interval <= '0;
                  held_q   <= 1'b0;
               end
            end
            S_WAIT_SECOND: begin
               // Second press wins over a coincident window timeout.
               if (rise) begin
                  state    <= S_SECOND;
                  interval <= '0;
                  double_q <= 1'b1;
               end else if (double_hit) begin
                  state    <= S_IDLE;
                  interval <= '0;
                  short_q  <= 1'b1;
               end
            end
            S_SECOND: begin
               if (fall) begin
                  state    <= S_IDLE;
                  interval <= '0;
               end
            end
            default: begin
               state    <= S_IDLE;
               interval <= '0;
               held_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_short  = short_q;
   assign bus.o_long   = long_q;
   assign bus.o_double = double_q;
   assign bus.o_held   = held_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with 4-cycle ticks, long = 8 ticks, double window = 4 ticks.
module tb_button_gesture_decoder;

   localparam int TICK   = 4;
   localparam int LONG   = 8;
   localparam int DOUBLE = 4;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;
   int   cyc;
   int   n_short, n_long, n_double, n_multi, n_held_rise;
   int   last_short, last_long, last_double, held_rise, held_fall;
   logic held_prev;
   int   k, r, w, t;

   button_gesture_decoder_if bif ();

   button_gesture_decoder #(
      .TICK_SCALE   (2),
      .LONG_TICKS   (LONG),
      .DOUBLE_TICKS (DOUBLE)
   ) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge index of the n-th counted tick after a state entered at edge w.
   function automatic int nth_tick(input int we, input int n);
      return ((we / TICK) + 1) * TICK + TICK * (n - 1);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear_counts();
      n_short = 0; n_long = 0; n_double = 0; n_multi = 0; n_held_rise = 0;
      last_short = -1; last_long = -1; last_double = -1;
      held_rise = -1; held_fall = -1;
      held_prev = bif.o_held;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bif.o_short)  begin n_short++;  last_short  = cyc; end
         if (bif.o_long)   begin n_long++;   last_long   = cyc; end
         if (bif.o_double) begin n_double++; last_double = cyc; end
         if ((int'(bif.o_short) + int'(bif.o_long) + int'(bif.o_double)) > 1) n_multi++;
         if (bif.o_held && !held_prev) begin n_held_rise++; held_rise = cyc; end
         if (!bif.o_held && held_prev) held_fall = cyc;
         held_prev = bif.o_held;
      end
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_pass  = 0;
      cyc     = 0;
      rst_n   = 1'b0;
      bif.i_button = 1'b0;
      clear_counts();

      // Reset state
      step(3);
      check("rst_short",  int'(bif.o_short),  0);
      check("rst_long",   int'(bif.o_long),   0);
      check("rst_double", int'(bif.o_double), 0);
      check("rst_held",   int'(bif.o_held),   0);
      rst_n = 1'b1;
      cyc = 0;
      clear_counts();
      step(5);

      // Short press: hold 10, release, wait 40
      clear_counts();
      k = cyc;
      bif.i_button = 1'b1;
      step(10);
      bif.i_button = 1'b0;
      step(40);
      check("short_count",  n_short, 1);
      check("short_time",   last_short, nth_tick(k + 13, DOUBLE));
      check("short_nolong", n_long, 0);
      check("short_nodbl",  n_double, 0);

      // Long press: hold 60, release
      clear_counts();
      k = cyc;
      bif.i_button = 1'b1;
      step(60);
      r = cyc;
      bif.i_button = 1'b0;
      step(30);
      check("long_count",     n_long, 1);
      check("long_time",      last_long, nth_tick(k + 3, LONG));
      check("held_rise",      held_rise, nth_tick(k + 3, LONG));
      check("held_rise_once", n_held_rise, 1);
      check("held_fall",      held_fall, r + 3);
      check("long_noshort",   n_short, 0);
      check("long_nodbl",     n_double, 0);

      // Double click: press 8, release 6, press 8, release
      clear_counts();
      k = cyc;
      bif.i_button = 1'b1;
      step(8);
      bif.i_button = 1'b0;
      step(6);
      bif.i_button = 1'b1;
      step(8);
      bif.i_button = 1'b0;
      step(40);
      check("dbl_count",   n_double, 1);
      check("dbl_time",    last_double, k + 17);
      check("dbl_noshort", n_short, 0);
      check("dbl_nolong",  n_long, 0);

      // Slow second press: two separate short presses
      clear_counts();
      k = cyc;
      bif.i_button = 1'b1;
      step(8);
      bif.i_button = 1'b0;
      step(30);
      check("slow_first_count", n_short, 1);
      check("slow_first_time",  last_short, nth_tick(k + 11, DOUBLE));
      bif.i_button = 1'b1;
      step(8);
      bif.i_button = 1'b0;
      step(30);
      check("slow_second_count", n_short, 2);
      check("slow_second_time",  last_short, nth_tick(k + 49, DOUBLE));
      check("slow_nodbl",        n_double, 0);

      // Boundary: second rise detected in the same cycle the window expires
      clear_counts();
      k = cyc;
      bif.i_button = 1'b1;
      step(8);
      bif.i_button = 1'b0;
      w = k + 11;
      t = nth_tick(w, DOUBLE);
      step_to(t - 3);
      bif.i_button = 1'b1;
      step_to(t);
      check("edge_dbl_now",  int'(bif.o_double), 1);
      check("edge_short_now", int'(bif.o_short), 0);
      step(8);
      bif.i_button = 1'b0;
      step(20);
      check("edge_dbl_count",   n_double, 1);
      check("edge_short_count", n_short, 0);
      check("edge_long_count",  n_long, 0);

      // Reset during S_LONG with the button held
      clear_counts();
      bif.i_button = 1'b1;
      step(45);
      check("pre_rst_held", int'(bif.o_held), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_short",  int'(bif.o_short),  0);
      check("mid_rst_long",   int'(bif.o_long),   0);
      check("mid_rst_double", int'(bif.o_double), 0);
      check("mid_rst_held",   int'(bif.o_held),   0);
      step(3);
      rst_n = 1'b1;
      cyc = 0;
      clear_counts();
      step(40);
      check("post_rst_long_count", n_long, 1);
      check("post_rst_long_time",  last_long, nth_tick(3, LONG));
      check("post_rst_held",       int'(bif.o_held), 1);
      check("post_rst_noshort",    n_short, 0);
      bif.i_button = 1'b0;
      step(20);
      check("post_rst_released", int'(bif.o_held), 0);

      check("one_pulse_per_cycle", n_multi, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
